// File: rtl/lsu_pkg.sv
// Shared definitions for the data-side memory arbiter: FSM states, line geometry
// and address slice positions.
package lsu_pkg;

  localparam int unsigned LINE_BEATS    = 16;
  localparam int unsigned OFFSET_BITS   = 7;  // 128-byte line
  localparam int unsigned INDEX_BITS    = 5;  // addr[11:7]
  localparam int unsigned BEAT_OFF_BITS = 3;  // 8-byte beat
  localparam int unsigned BEAT_BITS     = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_REFILL,
    ST_SINGLE,
    ST_DONE
  } arb_state_e;

  typedef enum logic {
    OWNER_LQ = 1'b0,
    OWNER_SB = 1'b1
  } owner_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; the pointer moves to the other input after
// every grant taken while advance_i is high.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] gnt_o
);

  // ptr_q = 0 favours req_i[0]
  logic ptr_q, ptr_d;

  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    if (req_i[0] && (!req_i[1] || !ptr_q)) begin
      gnt_o[0] = 1'b1;
    end else if (req_i[1]) begin
      gnt_o[1] = 1'b1;
    end
    if (advance_i && (|gnt_o)) begin
      ptr_d = gnt_o[0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/dcache_mem_arbiter.sv
// Data-side memory bus owner: arbitrates load-queue misses/uncached reads and
// store-buffer writes, and sequences 16-beat line refills into the data BRAM.
module dcache_mem_arbiter
  import lsu_pkg::*;
#(
  parameter int unsigned LINE_BEATS = lsu_pkg::LINE_BEATS
) (
  input  logic        core_clock_i,
  input  logic        core_reset_i,
  input  logic        core_flush_i,
  input  logic        lq_req_i,
  input  logic [31:0] lq_addr_i,
  input  logic [1:0]  lq_op_i,
  input  logic        lq_uncached_i,
  input  logic        lq_way_i,
  output logic        lq_cmp_o,
  output logic [31:0] lq_data_o,
  input  logic        sb_req_i,
  input  logic [31:0] sb_addr_i,
  input  logic [31:0] sb_data_i,
  input  logic [3:0]  sb_bm_i,
  output logic        sb_cmp_o,
  output logic        bus_req_valid_o,
  input  logic        bus_req_ready_i,
  output logic [31:0] bus_addr_o,
  output logic        bus_we_o,
  output logic        bus_burst_o,
  output logic [63:0] bus_wdata_o,
  output logic [7:0]  bus_bm_o,
  input  logic        bus_rsp_valid_i,
  input  logic [63:0] bus_rsp_data_i,
  input  logic        bus_rsp_last_i,
  output logic        refill_wr_en_o,
  output logic [9:0]  refill_wr_addr_o,
  output logic [63:0] refill_wr_data_o,
  output logic        tag_wr_en_o,
  output logic        tag_wr_way_o,
  output logic [23:0] tag_wr_line_o
);

  localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(LINE_BEATS - 1);

  arb_state_e  state_q, state_d;
  owner_e      owner_q, owner_d;
  logic        burst_q, burst_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [7:0]  bm_q, bm_d;
  logic        way_q, way_d;
  logic [BEAT_BITS-1:0] beat_q, beat_d;
  logic        last_seen_q, last_seen_d;
  logic [31:0] lq_data_q, lq_data_d;
  logic        wr_en_q, wr_en_d;
  logic [9:0]  wr_addr_q, wr_addr_d;
  logic [63:0] wr_data_q, wr_data_d;
  logic        tag_en_q, tag_en_d;
  logic        tag_way_q, tag_way_d;
  logic [23:0] tag_line_q, tag_line_d;

  logic [1:0]  gnt;
  logic        unused_inputs;

  // Flush never aborts a transaction; op size is extended by the LQ itself.
  assign unused_inputs = ^{core_flush_i, lq_op_i, sb_addr_i[1:0]};

  rr_arb2 u_arb (
    .clk_i     (core_clock_i),
    .rst_i     (core_reset_i),
    .req_i     ({sb_req_i, lq_req_i}),
    .advance_i (state_q == ST_IDLE),
    .gnt_o     (gnt)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    burst_d     = burst_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    bm_d        = bm_q;
    way_d       = way_q;
    beat_d      = beat_q;
    last_seen_d = last_seen_q;
    lq_data_d   = lq_data_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    tag_en_d    = 1'b0;
    tag_way_d   = tag_way_q;
    tag_line_d  = tag_line_q;

    unique case (state_q)
      ST_IDLE: begin
        beat_d      = '0;
        last_seen_d = 1'b0;
        if (gnt[0]) begin
          owner_d = OWNER_LQ;
          burst_d = !lq_uncached_i;
          we_d    = 1'b0;
          way_d   = lq_way_i;
          wdata_d = '0;
          bm_d    = '0;
          addr_d  = lq_uncached_i ? lq_addr_i
                                  : {lq_addr_i[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
          state_d = ST_REQ;
        end else if (gnt[1]) begin
          owner_d = OWNER_SB;
          burst_d = 1'b0;
          we_d    = 1'b1;
          way_d   = 1'b0;
          wdata_d = {sb_data_i, sb_data_i};
          bm_d    = sb_addr_i[BEAT_OFF_BITS-1] ? {sb_bm_i, 4'b0000} : {4'b0000, sb_bm_i};
          addr_d  = {sb_addr_i[31:BEAT_OFF_BITS], {BEAT_OFF_BITS{1'b0}}};
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus_req_ready_i) begin
          state_d = burst_q ? ST_REFILL : ST_SINGLE;
        end
      end
      ST_REFILL: begin
        // last_seen_q marks the cycle the final BRAM write is on the port
        if (last_seen_q) begin
          state_d = ST_DONE;
        end else if (bus_rsp_valid_i) begin
          wr_en_d   = 1'b1;
          wr_addr_d = {way_q, addr_q[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS], beat_q};
          wr_data_d = bus_rsp_data_i;
          beat_d    = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) begin
            tag_en_d   = 1'b1;
            tag_way_d  = way_q;
            tag_line_d = addr_q[30:OFFSET_BITS];
          end
          if (bus_rsp_last_i) begin
            last_seen_d = 1'b1;
          end
        end
      end
      ST_SINGLE: begin
        if (bus_rsp_valid_i) begin
          if (!we_q) begin
            lq_data_d = addr_q[BEAT_OFF_BITS-1] ? bus_rsp_data_i[63:32]
                                                : bus_rsp_data_i[31:0];
          end
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge core_clock_i) begin
    if (core_reset_i) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWNER_LQ;
      burst_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      bm_q        <= '0;
      way_q       <= 1'b0;
      beat_q      <= '0;
      last_seen_q <= 1'b0;
      lq_data_q   <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      tag_en_q    <= 1'b0;
      tag_way_q   <= 1'b0;
      tag_line_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      burst_q     <= burst_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      bm_q        <= bm_d;
      way_q       <= way_d;
      beat_q      <= beat_d;
      last_seen_q <= last_seen_d;
      lq_data_q   <= lq_data_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      tag_en_q    <= tag_en_d;
      tag_way_q   <= tag_way_d;
      tag_line_q  <= tag_line_d;
    end
  end

  assign bus_req_valid_o  = (state_q == ST_REQ);
  assign bus_addr_o       = addr_q;
  assign bus_we_o         = we_q;
  assign bus_burst_o      = burst_q;
  assign bus_wdata_o      = wdata_q;
  assign bus_bm_o         = bm_q;
  assign lq_cmp_o         = (state_q == ST_DONE) && (owner_q == OWNER_LQ);
  assign sb_cmp_o         = (state_q == ST_DONE) && (owner_q == OWNER_SB);
  assign lq_data_o        = lq_data_q;
  assign refill_wr_en_o   = wr_en_q;
  assign refill_wr_addr_o = wr_addr_q;
  assign refill_wr_data_o = wr_data_q;
  assign tag_wr_en_o      = tag_en_q;
  assign tag_wr_way_o     = tag_way_q;
  assign tag_wr_line_o    = tag_line_q;

`ifndef SYNTHESIS
  always_ff @(posedge core_clock_i) begin
    if (!core_reset_i && state_q == ST_REFILL && !last_seen_q && bus_rsp_valid_i) begin
      a_early_last : assert (!bus_rsp_last_i || beat_q == LAST_BEAT);
      a_missing_last : assert (bus_rsp_last_i || beat_q != LAST_BEAT);
    end
  end
`endif

endmodule

// File: tb/tb_dcache_mem_arbiter.sv
// Scoreboard bench for dcache_mem_arbiter: the stimulus thread pushes expected
// bus requests, BRAM/tag writes and completions; a negedge monitor pops them.
module tb_dcache_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        lq_req, lq_unc, lq_way;
  logic [31:0] lq_addr;
  logic [1:0]  lq_op;
  logic        lq_cmp;
  logic [31:0] lq_data;
  logic        sb_req;
  logic [31:0] sb_addr, sb_data;
  logic [3:0]  sb_bm;
  logic        sb_cmp;
  logic        req_valid, req_ready;
  logic [31:0] bus_addr;
  logic        bus_we, bus_burst;
  logic [63:0] bus_wdata;
  logic [7:0]  bus_bm;
  logic        rsp_valid, rsp_last;
  logic [63:0] rsp_data;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        tag_en, tag_way;
  logic [23:0] tag_line;

  dcache_mem_arbiter #(.LINE_BEATS(16)) dut (
    .core_clock_i(clk), .core_reset_i(rst), .core_flush_i(flush),
    .lq_req_i(lq_req), .lq_addr_i(lq_addr), .lq_op_i(lq_op),
    .lq_uncached_i(lq_unc), .lq_way_i(lq_way), .lq_cmp_o(lq_cmp), .lq_data_o(lq_data),
    .sb_req_i(sb_req), .sb_addr_i(sb_addr), .sb_data_i(sb_data), .sb_bm_i(sb_bm),
    .sb_cmp_o(sb_cmp),
    .bus_req_valid_o(req_valid), .bus_req_ready_i(req_ready),
    .bus_addr_o(bus_addr), .bus_we_o(bus_we), .bus_burst_o(bus_burst),
    .bus_wdata_o(bus_wdata), .bus_bm_o(bus_bm),
    .bus_rsp_valid_i(rsp_valid), .bus_rsp_data_i(rsp_data), .bus_rsp_last_i(rsp_last),
    .refill_wr_en_o(wr_en), .refill_wr_addr_o(wr_addr), .refill_wr_data_o(wr_data),
    .tag_wr_en_o(tag_en), .tag_wr_way_o(tag_way), .tag_wr_line_o(tag_line)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct { logic [31:0] addr; bit we; bit burst; logic [63:0] wdata; logic [7:0] bm; } req_t;
  typedef struct { logic [9:0] addr; logic [63:0] data; int due; } wr_t;
  typedef struct { bit way; logic [23:0] line; int due; } tag_t;
  typedef struct { bit is_lq; logic [31:0] data; int due; } cmp_t;

  req_t exp_req[$];
  wr_t  exp_wr[$];
  tag_t exp_tag[$];
  cmp_t exp_cmp[$];

  // Reference state: round-robin preference and the last uncached word returned.
  bit          rr_lq = 1'b1;
  logic [31:0] last_unc = '0;
  bit          fix_data = 1'b0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexp(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: unexpected or missing event at cycle %0d", name, cyc);
  endtask

  // Monitor: every observable DUT event must match the head of its queue.
  always @(negedge clk) begin
    if (req_valid && req_ready) begin
      if (exp_req.size() == 0) unexp("bus_req");
      else begin
        req_t r;
        r = exp_req.pop_front();
        chk("bus_addr", 256'(bus_addr), 256'(r.addr));
        chk("bus_we", 256'(bus_we), 256'(r.we));
        chk("bus_burst", 256'(bus_burst), 256'(r.burst));
        if (r.we) begin
          chk("bus_wdata", 256'(bus_wdata), 256'(r.wdata));
          chk("bus_bm", 256'(bus_bm), 256'(r.bm));
        end
      end
    end
    if (wr_en) begin
      if (exp_wr.size() == 0) unexp("refill_wr");
      else begin
        wr_t w;
        w = exp_wr.pop_front();
        chk("wr_addr", 256'(wr_addr), 256'(w.addr));
        chk("wr_data", 256'(wr_data), 256'(w.data));
        chk("wr_cycle", 256'(cyc), 256'(w.due));
      end
    end
    if (tag_en) begin
      if (exp_tag.size() == 0) unexp("tag_wr");
      else begin
        tag_t t;
        t = exp_tag.pop_front();
        chk("tag_way", 256'(tag_way), 256'(t.way));
        chk("tag_line", 256'(tag_line), 256'(t.line));
        chk("tag_cycle", 256'(cyc), 256'(t.due));
      end
    end
    if (lq_cmp || sb_cmp) begin
      if (exp_cmp.size() == 0) unexp("cmp");
      else begin
        cmp_t c;
        c = exp_cmp.pop_front();
        chk("cmp_owner", 256'({lq_cmp, sb_cmp}), 256'(c.is_lq ? 2'b10 : 2'b01));
        if (c.is_lq) chk("lq_data", 256'(lq_data), 256'(c.data));
        chk("cmp_cycle", 256'(cyc), 256'(c.due));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string name);
    chk(name, 256'({req_valid, bus_addr, bus_we, bus_burst, bus_wdata, bus_bm,
                    wr_en, wr_addr, wr_data, tag_en, tag_way, tag_line,
                    lq_cmp, sb_cmp, lq_data}), '0);
  endtask

  task automatic drop_req(input bit is_lq);
    if (is_lq) lq_req = 1'b0;
    else sb_req = 1'b0;
  endtask

  task automatic serve(input bit is_lq, input bit burst, input bit we, input logic [31:0] a,
                       input bit way, input int bp, input int flush_k, input int reset_k);
    int t;
    logic [127:0] snap;
    logic [63:0]  d;
    t = 0;
    while (!req_valid && t < 100) begin tick(); t++; end
    if (!req_valid) begin unexp("req_valid_timeout"); drop_req(is_lq); return; end
    snap = {bus_addr, bus_we, bus_burst, bus_wdata, bus_bm};
    for (int i = 0; i < bp; i++) begin
      tick();
      chk("bp_valid", 256'(req_valid), 256'(1));
      chk("bp_fields", 256'({bus_addr, bus_we, bus_burst, bus_wdata, bus_bm}), 256'(snap));
    end
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    if (burst) begin
      for (int k = 0; k < 16; k++) begin
        repeat ($urandom_range(0, 2)) tick();
        d = fix_data ? 64'(k) : {$urandom, $urandom};
        rsp_valid = 1'b1;
        rsp_data  = d;
        rsp_last  = (k == 15);
        if (flush_k >= 0) flush = (k >= flush_k) && (k < flush_k + 3);
        if (k == reset_k) begin
          rst = 1'b1;
          tick();
          check_all_zero("reset_mid_refill_zero");
          rst = 1'b0;
          lq_req = 1'b0;
          rr_lq = 1'b1;
          last_unc = '0;
          for (int j = k + 1; j < 16; j++) begin
            rsp_data = {$urandom, $urandom};
            rsp_last = (j == 15);
            tick();
          end
          rsp_valid = 1'b0;
          rsp_last = 1'b0;
          return;
        end
        exp_wr.push_back('{addr: {way, a[11:7], 4'(k)}, data: d, due: cyc + 1});
        if (k == 15) begin
          exp_tag.push_back('{way: way, line: a[30:7], due: cyc + 1});
          exp_cmp.push_back('{is_lq: 1'b1, data: last_unc, due: cyc + 2});
        end
        tick();
        rsp_valid = 1'b0;
        rsp_last = 1'b0;
      end
      flush = 1'b0;
    end else begin
      repeat ($urandom_range(0, 3)) tick();
      d = fix_data ? 64'hDEADBEEF_12345678 : {$urandom, $urandom};
      rsp_valid = 1'b1;
      rsp_data  = d;
      rsp_last  = 1'b1;
      if (!we) last_unc = a[2] ? d[63:32] : d[31:0];
      exp_cmp.push_back('{is_lq: is_lq, data: last_unc, due: cyc + 1});
      tick();
      rsp_valid = 1'b0;
      rsp_last = 1'b0;
    end
    t = 0;
    while (!(is_lq ? lq_cmp : sb_cmp) && t < 10) begin tick(); t++; end
    if (!(is_lq ? lq_cmp : sb_cmp)) unexp("cmp_timeout");
    drop_req(is_lq);
  endtask

  // Issue one episode: LQ and/or SB request asserted together, served in
  // round-robin order predicted by the reference pointer.
  task automatic episode(input bit e_lq, input bit e_sb, input int bp, input int flush_k,
                         input int reset_k);
    bit first_lq;
    req_t rl, rs;
    rl = '{addr: lq_unc ? lq_addr : {lq_addr[31:7], 7'b0}, we: 1'b0, burst: !lq_unc,
           wdata: '0, bm: '0};
    rs = '{addr: {sb_addr[31:3], 3'b0}, we: 1'b1, burst: 1'b0, wdata: {sb_data, sb_data},
           bm: sb_addr[2] ? {sb_bm, 4'b0} : {4'b0, sb_bm}};
    first_lq = (e_lq && e_sb) ? rr_lq : e_lq;
    lq_req = e_lq;
    sb_req = e_sb;
    if (first_lq) begin
      exp_req.push_back(rl);
      if (e_sb) exp_req.push_back(rs);
    end else begin
      exp_req.push_back(rs);
      if (e_lq) exp_req.push_back(rl);
    end
    for (int n = 0; n < 2; n++) begin
      bit cur_lq;
      if (n == 1 && !(e_lq && e_sb)) break;
      cur_lq = (n == 0) ? first_lq : !first_lq;
      rr_lq = !cur_lq;
      if (cur_lq) serve(1'b1, !lq_unc, 1'b0, lq_addr, lq_way, bp, flush_k, reset_k);
      else serve(1'b0, 1'b0, 1'b1, sb_addr, 1'b0, bp, -1, -1);
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    lq_req = 1'b0; lq_addr = '0; lq_op = 2'd2; lq_unc = 1'b0; lq_way = 1'b0;
    sb_req = 1'b0; sb_addr = '0; sb_data = '0; sb_bm = '0;
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0; rsp_last = 1'b0;
    repeat (3) tick();
    check_all_zero("reset_outputs");
    rst = 1'b0;
    tick();

    // Uncached load and store arrive together right after reset.
    fix_data = 1'b1;
    lq_addr = 32'h8000_0004; lq_unc = 1'b1; lq_way = 1'b0;
    sb_addr = 32'h8000_0000; sb_data = 32'h1122_3344; sb_bm = 4'b0011;
    episode(1'b1, 1'b1, 0, -1, -1);
    chk("uncached_word", 256'(lq_data), 256'(32'hDEADBEEF));

    // Directed refill with 5 cycles of request backpressure.
    lq_addr = 32'h0000_1280; lq_unc = 1'b0; lq_way = 1'b1;
    episode(1'b1, 1'b0, 5, -1, -1);
    fix_data = 1'b0;

    // Flush asserted from beat 7 of a refill.
    lq_addr = $urandom; lq_way = 1'($urandom);
    episode(1'b1, 1'b0, 0, 7, -1);

    // Reset at beat 4 of a refill.
    lq_addr = $urandom; lq_way = 1'($urandom);
    episode(1'b1, 1'b0, 0, -1, 4);
    repeat (3) tick();
    check_all_zero("after_reset_idle");

    for (int e = 0; e < 40; e++) begin
      bit el, es;
      el = 1'($urandom);
      es = 1'($urandom);
      if (!el && !es) el = 1'b1;
      lq_addr = $urandom; lq_unc = 1'($urandom); lq_way = 1'($urandom);
      lq_op = 2'($urandom_range(0, 2));
      sb_addr = $urandom; sb_data = $urandom; sb_bm = 4'($urandom);
      repeat ($urandom_range(0, 2)) tick();
      episode(el, es, $urandom_range(0, 3), ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : -1, -1);
    end

    repeat (5) tick();
    chk("queues_drained", 256'(exp_req.size() + exp_wr.size() + exp_tag.size() + exp_cmp.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
